// File: rtl/baccarat_pkg.sv
// Shared types and game constants for the baccarat control slice.
// Card codes and hand scores are 4-bit; states cover one full round.
package baccarat_pkg;

    localparam int CARD_W  = 4;
    localparam int SCORE_W = 4;

    localparam logic [SCORE_W-1:0] NATURAL_MIN     = 4'd8;
    localparam logic [SCORE_W-1:0] PLAYER_DRAW_MAX = 4'd5;
    localparam logic [SCORE_W-1:0] BANKER_STAND    = 4'd7;

    typedef enum logic [3:0] {
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_CHK,
        S_P3,
        S_BCHK,
        S_D3,
        S_DONE
    } state_t;

    // Face cards, tens and the unused codes all count as zero.
    function automatic logic [SCORE_W-1:0] card_value(input logic [CARD_W-1:0] c);
        if (c >= 4'd1 && c <= 4'd9)
            return SCORE_W'(c);
        return '0;
    endfunction

endpackage

// File: rtl/baccarat_sequencer_if.sv
// Sequencer <-> datapath bundle: scores and third card in, strobes and lights out.
// master is the sequencer side, slave the datapath/board side.
interface baccarat_sequencer_if;

    logic [baccarat_pkg::SCORE_W-1:0] pscore;
    logic [baccarat_pkg::SCORE_W-1:0] dscore;
    logic [baccarat_pkg::CARD_W-1:0]  pcard3;
    logic load_pcard1;
    logic load_pcard2;
    logic load_pcard3;
    logic load_dcard1;
    logic load_dcard2;
    logic load_dcard3;
    logic player_win_light;
    logic dealer_win_light;
    logic game_done;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, game_done
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, game_done
    );

endinterface

// File: rtl/banker_draw_rule.sv
// Banker third-card table, applied after the player has drawn a third card.
// Pure combinational lookup on banker score and player third-card value.
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] value,
    output logic               draw
);

    always_comb begin
        draw = 1'b0;
        if (dscore < BANKER_STAND) begin
            case (dscore)
                4'd0, 4'd1, 4'd2: draw = 1'b1;
                4'd3:             draw = (value != 4'd8);
                4'd4:             draw = (value >= 4'd2 && value <= 4'd7);
                4'd5:             draw = (value >= 4'd4 && value <= 4'd7);
                4'd6:             draw = (value >= 4'd6 && value <= 4'd7);
                default:          draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_sequencer.sv
// Baccarat round controller: deals four cards, applies third-card rules,
// then lights the winner until the next reset.
module baccarat_sequencer
    import baccarat_pkg::*;
(
    input  logic                 slow_clock,
    input  logic                 reset,
    baccarat_sequencer_if.master bus
);

    state_t state;
    state_t state_nxt;
    logic   banker_draw;
    logic   natural;

    banker_draw_rule u_rule (
        .dscore (bus.dscore),
        .value  (card_value(bus.pcard3)),
        .draw   (banker_draw)
    );

    // Out-of-range scores (10..15) also land here and end the round.
    assign natural = (bus.pscore >= NATURAL_MIN) || (bus.dscore >= NATURAL_MIN);

    always_ff @(posedge slow_clock) begin
        if (reset)
            state <= S_P1;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_P1:   state_nxt = S_D1;
            S_D1:   state_nxt = S_P2;
            S_P2:   state_nxt = S_D2;
            S_D2:   state_nxt = S_CHK;
            S_CHK: begin
                if (natural)
                    state_nxt = S_DONE;
                else if (bus.pscore <= PLAYER_DRAW_MAX)
                    state_nxt = S_P3;
                else if (bus.dscore <= PLAYER_DRAW_MAX)
                    state_nxt = S_D3;
                else
                    state_nxt = S_DONE;
            end
            S_P3:   state_nxt = S_BCHK;
            S_BCHK: state_nxt = banker_draw ? S_D3 : S_DONE;
            S_D3:   state_nxt = S_DONE;
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_P1;
        endcase
    end

    // Reset masks every output in the same cycle it is asserted.
    always_comb begin
        bus.load_pcard1      = 1'b0;
        bus.load_pcard2      = 1'b0;
        bus.load_pcard3      = 1'b0;
        bus.load_dcard1      = 1'b0;
        bus.load_dcard2      = 1'b0;
        bus.load_dcard3      = 1'b0;
        bus.player_win_light = 1'b0;
        bus.dealer_win_light = 1'b0;
        bus.game_done        = 1'b0;
        if (!reset) begin
            unique case (state)
                S_P1: bus.load_pcard1 = 1'b1;
                S_D1: bus.load_dcard1 = 1'b1;
                S_P2: bus.load_pcard2 = 1'b1;
                S_D2: bus.load_dcard2 = 1'b1;
                S_P3: bus.load_pcard3 = 1'b1;
                S_D3: bus.load_dcard3 = 1'b1;
                S_DONE: begin
                    bus.game_done        = 1'b1;
                    bus.player_win_light = (bus.pscore >= bus.dscore);
                    bus.dealer_win_light = (bus.dscore >= bus.pscore);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Round-level bench: table of hands, per-cycle expected outputs via a queue.
// Plus a hand-written reset-in-S_P3 sequence.
module tb_baccarat_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;

    baccarat_sequencer_if bus ();

    baccarat_sequencer dut (
        .slow_clock (clk),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin, done}
    localparam logic [8:0] O_NONE = 9'b000000000;
    localparam logic [8:0] O_P1   = 9'b100000000;
    localparam logic [8:0] O_D1   = 9'b010000000;
    localparam logic [8:0] O_P2   = 9'b001000000;
    localparam logic [8:0] O_D2   = 9'b000100000;
    localparam logic [8:0] O_P3   = 9'b000010000;
    localparam logic [8:0] O_D3   = 9'b000001000;
    localparam logic [8:0] O_DONE = 9'b000000001;
    localparam logic [8:0] O_PW   = 9'b000000100;
    localparam logic [8:0] O_DW   = 9'b000000010;

    typedef struct {
        logic [3:0] chk_p;
        logic [3:0] chk_d;
        logic [3:0] c3;
        logic [3:0] fin_p;
        logic [3:0] fin_d;
        logic       exp_p3;
        logic       exp_d3;
        logic       exp_pw;
        logic       exp_dw;
    } vec_t;

    typedef struct {
        logic [3:0] ps;
        logic [3:0] ds;
        logic [3:0] c3;
        logic [8:0] exp;
        string      name;
    } step_t;

    vec_t  vecs[$];
    step_t sb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [8:0] obs();
        return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
                bus.load_dcard2, bus.load_pcard3, bus.load_dcard3,
                bus.player_win_light, bus.dealer_win_light, bus.game_done};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] ps, input logic [3:0] ds,
                        input logic [3:0] c3, input logic [8:0] exp,
                        input string name);
        step_t s;
        s.ps = ps;
        s.ds = ds;
        s.c3 = c3;
        s.exp = exp;
        s.name = name;
        sb.push_back(s);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        step_t s;
        logic [8:0] lights;
        string tag;
        tag = $sformatf("v%0d", idx);
        lights = O_DONE | (v.exp_pw ? O_PW : O_NONE) | (v.exp_dw ? O_DW : O_NONE);
        push(v.chk_p, v.chk_d, 4'd0, O_P1, {tag, "_p1"});
        push(v.chk_p, v.chk_d, 4'd0, O_D1, {tag, "_d1"});
        push(v.chk_p, v.chk_d, 4'd0, O_P2, {tag, "_p2"});
        push(v.chk_p, v.chk_d, 4'd0, O_D2, {tag, "_d2"});
        push(v.chk_p, v.chk_d, 4'd0, O_NONE, {tag, "_chk"});
        if (v.exp_p3) begin
            push(v.chk_p, v.chk_d, v.c3, O_P3, {tag, "_p3"});
            push(v.chk_p, v.chk_d, v.c3, O_NONE, {tag, "_bchk"});
        end
        if (v.exp_d3)
            push(v.fin_p, v.fin_d, v.c3, O_D3, {tag, "_d3"});
        push(v.fin_p, v.fin_d, v.c3, lights, {tag, "_done"});
        push(v.fin_p, v.fin_d, v.c3, lights, {tag, "_hold"});

        reset = 1'b1;
        bus.pscore = v.chk_p;
        bus.dscore = v.chk_d;
        bus.pcard3 = 4'd0;
        @(posedge clk);
        #1;
        check({tag, "_rst"}, O_NONE);
        reset = 1'b0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            bus.pscore = s.ps;
            bus.dscore = s.ds;
            bus.pcard3 = s.c3;
            #1;
            check(s.name, s.exp);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(input int cp, input int cd, input int c3,
                                input int fp, input int fd,
                                input bit p3, input bit d3,
                                input bit pw, input bit dw);
        vec_t v;
        v.chk_p = 4'(cp);
        v.chk_d = 4'(cd);
        v.c3 = 4'(c3);
        v.fin_p = 4'(fp);
        v.fin_d = 4'(fd);
        v.exp_p3 = p3;
        v.exp_d3 = d3;
        v.exp_pw = pw;
        v.exp_dw = dw;
        return v;
    endfunction

    initial begin
        bus.pscore = '0;
        bus.dscore = '0;
        bus.pcard3 = '0;

        vecs.push_back(mk(8, 3, 0, 8, 3, 0, 0, 1, 0));
        vecs.push_back(mk(4, 7, 5, 9, 7, 1, 0, 1, 0));
        vecs.push_back(mk(6, 5, 0, 6, 6, 0, 1, 1, 1));
        vecs.push_back(mk(2, 6, 6, 3, 8, 1, 1, 0, 1));
        vecs.push_back(mk(0, 6, 12, 1, 6, 1, 0, 0, 1));
        vecs.push_back(mk(5, 3, 8, 5, 3, 1, 0, 1, 0));
        vecs.push_back(mk(1, 2, 13, 1, 2, 1, 1, 0, 1));
        vecs.push_back(mk(3, 4, 1, 4, 4, 1, 0, 1, 1));
        vecs.push_back(mk(3, 4, 2, 4, 9, 1, 1, 0, 1));
        vecs.push_back(mk(2, 5, 4, 7, 5, 1, 1, 1, 0));
        vecs.push_back(mk(3, 5, 3, 4, 5, 1, 0, 0, 1));
        vecs.push_back(mk(3, 3, 9, 2, 3, 1, 1, 0, 1));
        vecs.push_back(mk(3, 7, 7, 6, 7, 1, 0, 0, 1));
        vecs.push_back(mk(7, 7, 0, 7, 7, 0, 0, 1, 1));
        vecs.push_back(mk(7, 6, 0, 7, 6, 0, 0, 1, 0));
        vecs.push_back(mk(3, 9, 0, 3, 9, 0, 0, 0, 1));
        vecs.push_back(mk(12, 2, 0, 12, 2, 0, 0, 1, 0));
        vecs.push_back(mk(6, 0, 0, 6, 1, 0, 1, 1, 0));

        foreach (vecs[i])
            run_vec(i, vecs[i]);

        // Reset asserted while in S_P3 restarts the round.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.pscore = 4'd4;
        bus.dscore = 4'd7;
        bus.pcard3 = 4'd5;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        check("mid_p3", O_P3);
        reset = 1'b1;
        #1;
        check("mid_rst", O_NONE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_p1", O_P1);
        @(posedge clk);
        #1;
        check("mid_d1", O_D1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
